// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the sample-memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 3;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_HOLD = 4;

    localparam int IDX_W  = 2;
    localparam int HOLD_W = 4;

    localparam logic [IDX_W-1:0] REQ_SENSOR = 2'd0;
    localparam logic [IDX_W-1:0] REQ_RADIO  = 2'd1;
    localparam logic [IDX_W-1:0] REQ_DEBUG  = 2'd2;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first valid requester at or after 'start'.
// Zero latency; no backpressure (pure function of its inputs).
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   start,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    localparam int SW = IDX_W + 1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SW-1:0]        sum;

    // Rotate so bit 0 of 'rot' is the requester at 'start'.
    assign dbl = {valid, valid};
    assign rot = NUM_REQ'(dbl >> start);

    always_comb begin
        any = 1'b0;
        idx = '0;
        sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && rot[k]) begin
                sum = {1'b0, start} + SW'(k);
                if (sum >= SW'(NUM_REQ)) begin
                    sum = sum - SW'(NUM_REQ);
                end
                any = 1'b1;
                idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single-port sample memory; read data is routed back by tag.
// Grant one cycle after request, mem strobe at +1, rsp at +3; tenure capped at MAX_HOLD beats.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_write,
    output logic                      mem_read,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy,
    output logic [1:0]                owner
);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_owner_q, last_owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_wr_q, mem_rd_q;
    logic              tag1_vld_q, tag2_vld_q;
    logic [IDX_W-1:0]  tag1_q, tag2_q;
    logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0] rsp_data_q;

    logic [IDX_W-1:0]  pick_start;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              own_vld;
    logic              beat;

    assign pick_start = (last_owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : last_owner_q + 1'b1;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid (req_valid),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign own_vld = req_valid[owner_q];
    assign beat    = (state_q == OWN) && own_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_q       <= hold_d;
        end
    end

    // IDLE never grants and always lasts a cycle, which bounds the wait of any requester.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_d       = hold_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    hold_d  = '0;
                end
            end
            OWN: begin
                req_ready[owner_q] = 1'b1;
                if (!own_vld || hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_vld_d = '0;
        if (tag2_vld_q) begin
            rsp_vld_d[tag2_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            tag1_vld_q  <= 1'b0;
            tag1_q      <= '0;
            tag2_vld_q  <= 1'b0;
            tag2_q      <= '0;
            rsp_vld_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            mem_wr_q   <= beat && req_write[owner_q];
            mem_rd_q   <= beat && !req_write[owner_q];
            if (beat) begin
                mem_addr_q  <= req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
                mem_wdata_q <= req_wdata[int'(owner_q)*DATA_W +: DATA_W];
            end
            // The tag travels alongside the read so data returns to whoever issued it.
            tag1_vld_q <= beat && !req_write[owner_q];
            tag1_q     <= owner_q;
            tag2_vld_q <= tag1_vld_q;
            tag2_q     <= tag1_q;
            rsp_vld_q  <= rsp_vld_d;
            if (tag2_vld_q) begin
                rsp_data_q <= mem_rdata;
            end
        end
    end

    assign mem_address = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_write   = mem_wr_q;
    assign mem_read    = mem_rd_q;
    assign rsp_valid   = rsp_vld_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q == OWN) || tag1_vld_q || tag2_vld_q;
    assign owner       = (state_q == OWN) ? owner_q : 2'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle model plus read-response scoreboard and directed scenarios.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_address;
    logic            mem_write, mem_read, busy;
    logic [1:0]      owner;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Single-port memory with one cycle of read latency, plus a reference copy for expectations.
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_address];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct { logic wr; logic [7:0] addr; logic [7:0] data; } beat_t;
    typedef struct { int req; logic [7:0] data; int due; } exp_t;

    beat_t bq0[$], bq1[$], bq2[$];
    exp_t  sb[$];

    task automatic push_beat(input int r, input logic wr, input logic [7:0] a, input logic [7:0] d);
        beat_t b;
        b.wr = wr; b.addr = a; b.data = d;
        case (r)
            0: bq0.push_back(b);
            1: bq1.push_back(b);
            default: bq2.push_back(b);
        endcase
    endtask

    // Driver: each requester presents the head of its queue until the model sees it accepted.
    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        forever begin
            @(posedge clk); #1;
            req_valid[0] = bq0.size() > 0;
            req_valid[1] = bq1.size() > 0;
            req_valid[2] = bq2.size() > 0;
            req_write = '0; req_addr = '0; req_wdata = '0;
            if (bq0.size() > 0) begin req_write[0] = bq0[0].wr; req_addr[0 +: 8] = bq0[0].addr; req_wdata[0 +: 8] = bq0[0].data; end
            if (bq1.size() > 0) begin req_write[1] = bq1[0].wr; req_addr[8 +: 8] = bq1[0].addr; req_wdata[8 +: 8] = bq1[0].data; end
            if (bq2.size() > 0) begin req_write[2] = bq2[0].wr; req_addr[16 +: 8] = bq2[0].addr; req_wdata[16 +: 8] = bq2[0].data; end
        end
    end

    // Reference arbiter state
    bit         m_own = 0;
    int         m_owner = 0, m_last = N - 1, m_hold = 0;
    bit         m_p1 = 0, m_p2 = 0;
    bit         exp_wr = 0, exp_rd = 0;
    logic [7:0] exp_addr = 0, exp_wdata = 0;
    int         cyc = 0;
    int         rsp_cnt [N] = '{0, 0, 0};
    int         rsp_seen = 0;
    logic [7:0] last_rsp_data = 0;
    bit         ten_act = 0;
    int         ten_beats = 0;
    int         grant_log[$], len_log[$];

    function automatic int m_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] oh);
        return oh[1] ? 1 : (oh[2] ? 2 : 0);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            begin
                logic [N-1:0] m_ready, exp_rsp;
                bit beat;
                int p;
                m_ready = m_own ? N'(1 << m_owner) : '0;
                check_eq("req_ready", 32'(req_ready), 32'(m_ready));
                check_eq("owner", 32'(owner), m_own ? m_owner : 0);
                check_eq("busy", 32'(busy), 32'(m_own || m_p1 || m_p2));
                check_eq("mem_write", 32'(mem_write), 32'(exp_wr));
                check_eq("mem_read", 32'(mem_read), 32'(exp_rd));
                if (exp_wr || exp_rd) check_eq("mem_address", 32'(mem_address), 32'(exp_addr));
                if (exp_wr) check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
                exp_rsp = '0;
                if (sb.size() > 0 && sb[0].due == cyc) exp_rsp = N'(1 << sb[0].req);
                check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
                if (exp_rsp != 0) begin
                    check_eq("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                    void'(sb.pop_front());
                end
                for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_cnt[i]++;
                if (rsp_valid != 0) begin rsp_seen++; last_rsp_data = rsp_data; end

                // Tenure log taken from the DUT's own grants for the ordering checks.
                if (req_ready != 0) begin
                    if (!ten_act) begin ten_act = 1; ten_beats = 0; grant_log.push_back(oh2idx(req_ready)); end
                    if ((req_ready & req_valid) != 0) ten_beats++;
                end else if (ten_act) begin
                    ten_act = 0;
                    len_log.push_back(ten_beats);
                end

                if (rst) begin
                    m_own = 0; m_owner = 0; m_last = N - 1; m_hold = 0;
                    m_p1 = 0; m_p2 = 0; exp_wr = 0; exp_rd = 0;
                    sb.delete();
                end else begin
                    beat = m_own && req_valid[m_owner];
                    exp_wr = beat && req_write[m_owner];
                    exp_rd = beat && !req_write[m_owner];
                    if (beat) begin
                        exp_addr  = req_addr[m_owner*8 +: 8];
                        exp_wdata = req_wdata[m_owner*8 +: 8];
                        if (exp_wr) ref_mem[exp_addr] = exp_wdata;
                        else sb.push_back('{m_owner, ref_mem[exp_addr], cyc + 3});
                        case (m_owner)
                            0: void'(bq0.pop_front());
                            1: void'(bq1.pop_front());
                            default: void'(bq2.pop_front());
                        endcase
                    end
                    m_p2 = m_p1;
                    m_p1 = exp_rd;
                    if (!m_own) begin
                        p = m_pick(req_valid, m_last);
                        if (p >= 0) begin m_own = 1; m_owner = p; m_hold = 0; end
                    end else if (!req_valid[m_owner] || m_hold == MH - 1) begin
                        m_own = 0; m_last = m_owner;
                    end else begin
                        m_hold++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = bq0.size() == 0 && bq1.size() == 0 && bq2.size() == 0 &&
                 sb.size() == 0 && !m_own && !m_p1 && !m_p2;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bit ok;
        int base;
        int c0, c1, c2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            check_eq("idle_ctl", 32'({req_ready, rsp_valid, mem_write, mem_read, busy, owner}), 32'd0);
            check_eq("idle_dat", 32'({mem_address, mem_wdata, rsp_data}), 32'd0);
        end

        // Write then read back from the sensor port
        base = rsp_seen;
        push_beat(int'(REQ_SENSOR), 1'b1, 8'h10, 8'hA5);
        push_beat(int'(REQ_SENSOR), 1'b0, 8'h10, 8'h00);
        wait_drain(100, ok);
        check_eq("wr_rd_drain", 32'(ok), 32'd1);
        check_eq("wr_rd_rsp_cnt", rsp_seen - base, 32'd1);
        check_eq("wr_rd_data", 32'(last_rsp_data), 32'hA5);

        // All three requesters stream reads continuously
        do_reset();
        grant_log.delete(); len_log.delete();
        c0 = rsp_cnt[0]; c1 = rsp_cnt[1]; c2 = rsp_cnt[2];
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 2 * MH; k++)
                push_beat(r, 1'b0, 8'(8'h40 + r * 16 + k), 8'h00);
        wait_drain(300, ok);
        check_eq("rr_drain", 32'(ok), 32'd1);
        check_eq("rr_tenures", grant_log.size(), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check_eq("rr_order", grant_log[i], i % 3);
        for (int i = 0; i < 6 && i < len_log.size(); i++) check_eq("rr_len", len_log[i], MH);
        check_eq("rr_rsp_sensor", rsp_cnt[0] - c0, 2 * MH);
        check_eq("rr_rsp_radio", rsp_cnt[1] - c1, 2 * MH);
        check_eq("rr_rsp_debug", rsp_cnt[2] - c2, 2 * MH);

        // Reset lands one cycle after a radio read handshake
        do_reset();
        push_beat(int'(REQ_RADIO), 1'b0, 8'h22, 8'h00);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bq1.size() == 0;
        end
        check_eq("rst_hs_seen", 32'(ok), 32'd1);
        base = rsp_seen;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_strobe", 32'({mem_read, mem_write}), 32'd0);
        repeat (6) @(negedge clk);
        check_eq("rst_no_rsp", rsp_seen - base, 32'd0);
        grant_log.delete(); len_log.delete();
        push_beat(int'(REQ_DEBUG), 1'b0, 8'h33, 8'h00);
        push_beat(int'(REQ_SENSOR), 1'b0, 8'h34, 8'h00);
        wait_drain(100, ok);
        check_eq("rst_drain", 32'(ok), 32'd1);
        check_eq("rst_grants", grant_log.size(), 32'd2);
        if (grant_log.size() > 1) begin
            check_eq("rst_first_grant", grant_log[0], 32'd0);
            check_eq("rst_second_grant", grant_log[1], 32'd2);
        end

        // Sensor releases early while radio waits; radio reads what sensor wrote
        do_reset();
        grant_log.delete(); len_log.delete();
        push_beat(int'(REQ_SENSOR), 1'b1, 8'h80, 8'h3C);
        push_beat(int'(REQ_SENSOR), 1'b1, 8'h81, 8'hC3);
        push_beat(int'(REQ_RADIO), 1'b0, 8'h80, 8'h00);
        push_beat(int'(REQ_RADIO), 1'b0, 8'h81, 8'h00);
        wait_drain(100, ok);
        check_eq("drop_drain", 32'(ok), 32'd1);
        check_eq("drop_grants", grant_log.size(), 32'd2);
        if (grant_log.size() > 1) begin
            check_eq("drop_first", grant_log[0], 32'd0);
            check_eq("drop_second", grant_log[1], 32'd1);
            check_eq("drop_len", len_log[0], 32'd2);
        end
        check_eq("drop_last_data", 32'(last_rsp_data), 32'hC3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
